// File: rtl/note_recorder.sv
// Key-press recorder: timestamps held keys in ms ticks and emits one
// {note, start, end} record per note into an external record memory.
module note_recorder #(
    parameter int TICK_DIV  = 50000,
    parameter int ADDR_W    = 6,
    parameter int MIN_TICKS = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              record_en,
    input  logic              key_down,
    input  logic [3:0]        key_note,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [61:0]       wr_data,
    output logic [ADDR_W:0]   note_count,
    output logic              full,
    output logic [28:0]       time_now
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [28:0]     TIME_MAX   = '1;
    localparam logic [ADDR_W:0] MEM_SLOTS  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HELD, S_EMIT, S_FULL} state_t;

    state_t            state_reg, state_next;
    logic              rec_en_prev_reg;
    logic [PW-1:0]     presc_reg, presc_next;
    logic [28:0]       time_reg, time_next;
    logic [3:0]        note_reg, note_next;
    logic [28:0]       start_reg, start_next;
    logic [61:0]       rec_data_reg, rec_data_next;
    logic              pending_reg, pending_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              full_reg, full_next;

    logic              rise;
    logic              too_short;
    logic [ADDR_W:0]   count_inc;

    assign rise      = record_en & ~rec_en_prev_reg;
    assign too_short = (time_reg - start_reg) < 29'(MIN_TICKS);
    assign count_inc = count_reg + (ADDR_W+1)'(1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            rec_en_prev_reg <= 1'b1;  // a fresh rising edge is needed after reset
            presc_reg       <= '0;
            time_reg        <= '0;
            note_reg        <= '0;
            start_reg       <= '0;
            rec_data_reg    <= '0;
            pending_reg     <= 1'b0;
            wptr_reg        <= '0;
            count_reg       <= '0;
            full_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rec_en_prev_reg <= record_en;
            presc_reg       <= presc_next;
            time_reg        <= time_next;
            note_reg        <= note_next;
            start_reg       <= start_next;
            rec_data_reg    <= rec_data_next;
            pending_reg     <= pending_next;
            wptr_reg        <= wptr_next;
            count_reg       <= count_next;
            full_reg        <= full_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        time_next     = time_reg;
        note_next     = note_reg;
        start_next    = start_reg;
        rec_data_next = rec_data_reg;
        pending_next  = pending_reg;
        wptr_next     = wptr_reg;
        count_next    = count_reg;
        full_next     = full_reg;

        if (record_en) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                if (time_reg != TIME_MAX)
                    time_next = time_reg + 29'd1;
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (rise)
                    state_next = S_ARMED;
            end
            S_ARMED: begin
                if (!record_en) begin
                    state_next = S_IDLE;
                end else if (key_down) begin
                    note_next  = key_note;
                    start_next = time_reg;
                    state_next = S_HELD;
                end
            end
            S_HELD: begin
                if (!record_en) begin
                    pending_next = 1'b0;
                    if (too_short) begin
                        state_next = S_IDLE;
                    end else begin
                        rec_data_next = {note_reg, start_reg, time_reg};
                        state_next    = S_EMIT;
                    end
                end else if (!key_down) begin
                    if (too_short) begin
                        state_next = S_ARMED;
                    end else begin
                        rec_data_next = {note_reg, start_reg, time_reg};
                        state_next    = S_EMIT;
                    end
                end else if (key_note != note_reg) begin
                    // The new note opens now; the old one is captured in rec_data.
                    note_next  = key_note;
                    start_next = time_reg;
                    if (!too_short) begin
                        rec_data_next = {note_reg, start_reg, time_reg};
                        pending_next  = 1'b1;
                        state_next    = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (wr_ready) begin
                    wptr_next  = wptr_reg + ADDR_W'(1);
                    count_next = count_inc;
                    if (count_inc == MEM_SLOTS) begin
                        full_next    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = S_FULL;
                    end else if (pending_reg) begin
                        pending_next = 1'b0;
                        state_next   = S_HELD;
                    end else if (!record_en) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ARMED;
                    end
                end
            end
            S_FULL: begin
                if (!record_en)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // A new session restarts the clock and the memory regardless of state.
        if (rise) begin
            presc_next = '0;
            time_next  = '0;
            wptr_next  = '0;
            count_next = '0;
            full_next  = 1'b0;
        end
    end

    assign wr_valid   = (state_reg == S_EMIT);
    assign wr_data    = wr_valid ? rec_data_reg : '0;
    assign wr_addr    = wptr_reg;
    assign note_count = count_reg;
    assign full       = full_reg;
    assign time_now   = time_reg;
endmodule

// File: tb/tb_note_recorder.sv
// Directed scoreboard bench for note_recorder with TICK_DIV=4, ADDR_W=2, MIN_TICKS=2.
module tb_note_recorder;
    logic        CLOCK_50;
    logic        reset;
    logic        record_en;
    logic        key_down;
    logic [3:0]  key_note;
    logic        wr_ready;
    logic        wr_valid;
    logic [1:0]  wr_addr;
    logic [61:0] wr_data;
    logic [2:0]  note_count;
    logic        full;
    logic [28:0] time_now;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int idle_data_viol = 0;

    logic [1:0]  exp_addr_q[$];
    logic [61:0] exp_data_q[$];

    note_recorder #(.TICK_DIV(4), .ADDR_W(2), .MIN_TICKS(2)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .record_en  (record_en),
        .key_down   (key_down),
        .key_note   (key_note),
        .wr_ready   (wr_ready),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .note_count (note_count),
        .full       (full),
        .time_now   (time_now)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [61:0] mk(input int n, input int s, input int e);
        return {4'(n), 29'(s), 29'(e)};
    endfunction

    // Monitor: pops the scoreboard on every accepted write.
    always @(negedge CLOCK_50) begin
        if (!wr_valid && wr_data != '0) idle_data_viol++;
        if (wr_valid) valid_cycles++;
        if (!reset && wr_valid && wr_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", wr_addr, wr_data);
            end else begin
                logic [1:0]  ea;
                logic [61:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                checks++;
                if (wr_addr !== ea) begin
                    errors++;
                    $display("FAIL write_addr: got %0d expected %0d", wr_addr, ea);
                end
                checks++;
                if (wr_data !== ed) begin
                    errors++;
                    $display("FAIL write_data: got %h expected %h", wr_data, ed);
                end else begin
                    $display("write addr=%0d note=%0d start=%0d end=%0d",
                             wr_addr, wr_data[61:58], wr_data[57:29], wr_data[28:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_time(input int t);
        int k = 0;
        while (time_now != 29'(t) && k < 400) begin
            step(1);
            k++;
        end
        if (time_now != 29'(t)) begin
            checks++;
            errors++;
            $display("FAIL wait_time: got %0d expected %0d", time_now, t);
        end
    endtask

    task automatic press(input int n, input int t0, input int t1);
        wait_time(t0);
        key_note = 4'(n);
        key_down = 1'b1;
        wait_time(t1);
        key_down = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_data_q.size() != 0 && k < 50) begin
            step(1);
            k++;
        end
        chk(name, 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic start_session;
        key_down  = 1'b0;
        record_en = 1'b0;
        step(2);
        record_en = 1'b1;
        step(1);
    endtask

    task automatic expect_write(input int a, input logic [61:0] d);
        exp_addr_q.push_back(2'(a));
        exp_data_q.push_back(d);
    endtask

    initial begin
        int vc;
        int k;
        reset     = 1'b1;
        record_en = 1'b0;
        key_down  = 1'b0;
        key_note  = 4'd0;
        wr_ready  = 1'b1;
        step(3);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_note_count", 64'(note_count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_time_now", 64'(time_now), 64'd0);
        reset = 1'b0;
        step(2);

        // Single valid note
        start_session();
        chk("session_time0", 64'(time_now), 64'd0);
        expect_write(0, mk(5, 3, 10));
        press(5, 3, 10);
        drain("n1_written");
        chk("n1_count", 64'(note_count), 64'd1);

        // Too-short press discarded, then a valid one lands at addr 0
        start_session();
        press(4, 4, 5);
        step(4);
        chk("short_count", 64'(note_count), 64'd0);
        chk("short_no_valid", 64'(wr_valid), 64'd0);
        expect_write(0, mk(1, 7, 9));
        press(1, 7, 9);
        drain("after_short_written");
        chk("after_short_count", 64'(note_count), 64'd1);

        // Note change while held splits into two records
        start_session();
        expect_write(0, mk(2, 1, 6));
        expect_write(1, mk(7, 6, 9));
        wait_time(1);
        key_note = 4'd2;
        key_down = 1'b1;
        wait_time(6);
        key_note = 4'd7;
        wait_time(9);
        key_down = 1'b0;
        drain("change_written");
        chk("change_count", 64'(note_count), 64'd2);

        // Backpressure: outputs hold steady while wr_ready=0
        wr_ready = 1'b0;
        start_session();
        expect_write(0, mk(3, 2, 5));
        press(3, 2, 5);
        k = 0;
        while (!wr_valid && k < 20) begin step(1); k++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(wr_valid), 64'd1);
            chk("bp_addr", 64'(wr_addr), 64'd0);
            chk("bp_data", 64'(wr_data), 64'(mk(3, 2, 5)));
            step(1);
        end
        wr_ready = 1'b1;
        drain("bp_written");
        step(1);
        chk("bp_count", 64'(note_count), 64'd1);
        chk("bp_valid_dropped", 64'(wr_valid), 64'd0);

        // Fill the memory
        start_session();
        expect_write(0, mk(1, 1, 3));
        expect_write(1, mk(2, 4, 6));
        expect_write(2, mk(3, 7, 9));
        expect_write(3, mk(4, 10, 12));
        press(1, 1, 3);
        press(2, 4, 6);
        press(3, 7, 9);
        press(4, 10, 12);
        drain("fill_written");
        chk("fill_count", 64'(note_count), 64'd4);
        chk("fill_full", 64'(full), 64'd1);
        vc = valid_cycles;
        press(5, 13, 15);
        step(4);
        chk("full_no_write", 64'(valid_cycles - vc), 64'd0);
        record_en = 1'b0;
        step(2);
        chk("full_held_idle", 64'(full), 64'd1);
        record_en = 1'b1;
        step(1);
        chk("rise_clears_full", 64'(full), 64'd0);
        chk("rise_clears_count", 64'(note_count), 64'd0);
        chk("rise_clears_time", 64'(time_now), 64'd0);

        // Reset in the middle of an emit abandons the record
        wr_ready = 1'b0;
        press(6, 1, 4);
        k = 0;
        while (!wr_valid && k < 20) begin step(1); k++; end
        chk("emit_reached", 64'(wr_valid), 64'd1);
        step(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_data", 64'(wr_data), 64'd0);
        chk("mid_rst_count", 64'(note_count), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_time", 64'(time_now), 64'd0);
        wr_ready = 1'b1;
        step(2);
        vc = valid_cycles;
        reset = 1'b0;
        key_note = 4'd7;
        key_down = 1'b1;
        step(20);
        key_down = 1'b0;
        step(4);
        chk("no_write_after_rst", 64'(valid_cycles - vc), 64'd0);

        chk("wr_data_zero_when_idle", 64'(idle_data_viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_recorder.md
NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter TICK_DIV, default 50000, CLOCK_50 cycles per timestamp tick (1 ms at 50 MHz).
REQ-002 Parameter ADDR_W, default 6, record-memory address width (2^ADDR_W records).
REQ-003 Parameter MIN_TICKS, default 2, minimum note length in ticks; shorter presses are discarded.
REQ-004 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 record_en  in  1  level; recording session active while high.
REQ-007 key_down  in  1  level; a key is held (already synchronised and debounced upstream).
REQ-008 key_note  in  4  note index of held key; meaningful only while key_down=1.
REQ-009 wr_ready  in  1  record memory accepts a write this cycle.
REQ-010 wr_valid  out  1  record write request.
REQ-011 wr_addr  out  ADDR_W  record slot being written.
REQ-012 wr_data  out  62  record {note[61:58], start[57:29], end[28:0]}; same packing the tone generator consumes.
REQ-013 note_count  out  ADDR_W+1  records committed this session.
REQ-014 full  out  1  memory full; recording halted.
REQ-015 time_now  out  29  current session timestamp in ticks.

Function
REQ-016 Prescaler counts 0..TICK_DIV-1 while record_en=1; on wrap, time_now increments, saturating at 29'h1FFFFFFF.
REQ-017 record_en rising edge (registered previous value 0, current 1): prescaler, time_now, write pointer, note_count, full cleared to 0 in that cycle.
REQ-018 States: IDLE, ARMED, HELD, EMIT, FULL.
REQ-019 IDLE: wr_valid=0; record_en rising -> ARMED.
REQ-020 ARMED: key_down=1 -> latch note=key_note, start=time_now; -> HELD next cycle.
REQ-021 HELD, key_down=0: end=time_now; if end-start < MIN_TICKS -> ARMED, no write; else -> EMIT.
REQ-022 HELD, key_down=1 and key_note != latched note: close record with end=time_now (MIN_TICKS check applies), set pending-open with new note and start=time_now; -> EMIT, or directly HELD on new note if discarded.
REQ-023 HELD, record_en falls: close record with end=time_now (MIN_TICKS check applies) -> EMIT then IDLE, or IDLE if discarded.
REQ-024 EMIT: wr_valid=1; wr_addr, wr_data held stable until wr_valid & wr_ready.
REQ-025 On accepted write: pointer and note_count increment in the same cycle; wr_valid drops next cycle.
REQ-026 EMIT exit order: count = 2^ADDR_W -> FULL; else pending-open -> HELD; else record_en=0 -> IDLE; else ARMED.
REQ-027 Key activity during EMIT not observed; ARMED with key_down still 1 opens a new note at current time_now.
REQ-028 FULL: full=1, wr_valid=0, keys ignored; record_en low -> IDLE with full held at 1 until next record_en rising edge.
REQ-029 record_en falling in ARMED -> IDLE; time_now freezes (no ticks while record_en=0).
REQ-030 Records always satisfy end >= start; saturated time_now used as-is for start and end.
REQ-031 wr_data = 0 whenever wr_valid=0.

Reset
REQ-032 reset=1 forces immediately: state IDLE, wr_valid=0, wr_addr=0, wr_data=0, note_count=0, full=0, time_now=0, prescaler=0, pending-open cleared.
REQ-033 Reset during EMIT abandons the record; no write completes after reset asserts.
REQ-034 After reset release with record_en already 1, a new rising edge is required before recording (registered previous record_en resets to 1).

Verification (TICK_DIV=4, ADDR_W=2, MIN_TICKS=2)
REQ-035 record_en rise, key_note=5 down at time 3, up at time 10, wr_ready=1 -> one write, addr 0, data {4'd5, 29'd3, 29'd10}, note_count=1.
REQ-036 key down at time 4, up at time 5 -> no write, note_count stays 0, state ARMED.
REQ-037 Note 2 held from time 1, key_note changes to 7 at time 6, released at time 9 -> writes {2,1,6} then {7,6,9} at addr 0,1.
REQ-038 wr_ready=0 for 5 cycles in EMIT -> wr_valid, wr_addr, wr_data stable all 5 cycles; single write on first wr_ready=1.
REQ-039 Four valid notes -> note_count=4, full=1; fifth key press produces no wr_valid; record_en fall then rise clears full and count.
REQ-040 reset pulse mid-EMIT with wr_ready=0 -> wr_valid=0 same cycle, all outputs 0, no write after release.
